// File: rtl/hsid_x_ctrl_mon_pkg.sv
// Shared types and constants for the HSpecID-X control-handshake monitor.
package hsid_pkg;

    localparam int HSID_WORD_WIDTH        = 32;
    localparam int HSID_HSP_LIBRARY_WIDTH = 8;
    localparam int HSID_X_MON_NUM_VIOL    = 6;

    typedef enum logic [2:0] {
        MON_START_LONG   = 3'd0,
        MON_CLEAR_LONG   = 3'd1,
        MON_START_BUSY   = 3'd2,
        MON_MULTI_INT    = 3'd3,
        MON_RES_MISMATCH = 3'd4,
        MON_TIMEOUT      = 3'd5
    } hsid_x_mon_code_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_RES_CHK = 2'd2
    } hsid_x_mon_state_e;

endpackage

// File: rtl/hsid_x_ctrl_mon_ch.sv
// One monitored channel: handshake FSM, detectors, sticky flags, violation counter.
// HSID_X_MON_WATCHDOG_EN adds the busy counter and TIMEOUT detection.
module hsid_x_ctrl_mon_ch
    import hsid_pkg::*;
#(
    parameter int RES_WIDTH = 2*HSID_WORD_WIDTH + 2*HSID_HSP_LIBRARY_WIDTH,
    parameter int CNT_WIDTH = 8,
    parameter int TMO_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           mon_en,
    input  logic                           mon_clear,
    input  logic [TMO_WIDTH-1:0]           tmo_limit,
    input  logic                           start,
    input  logic                           clear,
    input  logic                           done,
    input  logic                           error,
    input  logic                           cancelled,
    input  logic [RES_WIDTH-1:0]           res_src,
    input  logic [RES_WIDTH-1:0]           res_reg,
    output logic [HSID_X_MON_NUM_VIOL-1:0] viol,
    output logic [HSID_X_MON_NUM_VIOL-1:0] sticky,
    output logic [CNT_WIDTH-1:0]           cnt
);

    hsid_x_mon_state_e             state;
    logic                          start_q, clear_q;
    logic                          hs_int, multi, any_viol;
    logic [HSID_X_MON_NUM_VIOL-1:0] det;

    assign hs_int = done | error | cancelled;
    assign multi  = (done & error) | (done & cancelled) | (error & cancelled);

`ifdef HSID_X_MON_WATCHDOG_EN
    logic [TMO_WIDTH-1:0] busy_cnt;
    logic                 tmo_hit;
`else
    logic unused_tmo;
    assign unused_tmo = ^tmo_limit;
`endif

    always_comb begin
        det = '0;
        det[MON_START_LONG]   = start & start_q;
        det[MON_CLEAR_LONG]   = clear & clear_q;
        det[MON_START_BUSY]   = start & ~start_q & (state == ST_RUN);
        det[MON_MULTI_INT]    = multi;
        det[MON_RES_MISMATCH] = (state == ST_RES_CHK) && (res_reg != res_src);
`ifdef HSID_X_MON_WATCHDOG_EN
        det[MON_TIMEOUT]      = (state == ST_RUN) && (tmo_limit != '0) &&
                                (busy_cnt == tmo_limit) && !tmo_hit;
`endif
        // History and FSM keep tracking while masked, so re-enable is clean.
        viol = mon_en ? det : '0;
    end

    assign any_viol = |viol;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            start_q <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            start_q <= start;
            clear_q <= clear;
            case (state)
                ST_IDLE:    if (start) state <= ST_RUN;
                ST_RUN: begin
                    if (hs_int)     state <= ST_RES_CHK;
                    else if (clear) state <= ST_IDLE;
                end
                ST_RES_CHK: state <= start ? ST_RUN : ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

`ifdef HSID_X_MON_WATCHDOG_EN
    // Counter is zero in the first RUN cycle; tmo_hit limits TIMEOUT to one per episode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt <= '0;
            tmo_hit  <= 1'b0;
        end else if (state != ST_RUN) begin
            busy_cnt <= '0;
            tmo_hit  <= 1'b0;
        end else begin
            if (busy_cnt != '1) busy_cnt <= busy_cnt + 1'b1;
            if (det[MON_TIMEOUT]) tmo_hit <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky <= '0;
            cnt    <= '0;
        end else if (mon_clear) begin
            sticky <= viol;
            cnt    <= CNT_WIDTH'(any_viol);
        end else begin
            sticky <= sticky | viol;
            if (any_viol && cnt != '1) cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hsid_x_ctrl_mon.sv
// Multi-channel HSpecID-X handshake monitor: per-channel checkers, first-error capture, irq.
// HSID_X_MON_WATCHDOG_EN enables the per-channel busy watchdog (code 5).
module hsid_x_ctrl_mon
    import hsid_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int RES_WIDTH = 2*HSID_WORD_WIDTH + 2*HSID_HSP_LIBRARY_WIDTH,
    parameter int CNT_WIDTH = 8,
    parameter int TMO_WIDTH = 16,
    localparam int NV       = HSID_X_MON_NUM_VIOL,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          mon_en,
    input  logic                          mon_clear,
    input  logic [TMO_WIDTH-1:0]          tmo_limit,
    input  logic [NUM_CH-1:0]             start,
    input  logic [NUM_CH-1:0]             clear,
    input  logic [NUM_CH-1:0]             idle,
    input  logic [NUM_CH-1:0]             done,
    input  logic [NUM_CH-1:0]             error,
    input  logic [NUM_CH-1:0]             cancelled,
    input  logic [NUM_CH*RES_WIDTH-1:0]   res_src,
    input  logic [NUM_CH*RES_WIDTH-1:0]   res_reg,
    output logic [NUM_CH*NV-1:0]          viol_sticky,
    output logic [NUM_CH*CNT_WIDTH-1:0]   viol_cnt,
    output logic                          first_valid,
    output logic [CH_W-1:0]               first_ch,
    output logic [2:0]                    first_code,
    output logic                          irq
);

    logic [NUM_CH-1:0][NV-1:0] viol;
    logic                      hit;
    logic [CH_W-1:0]           fch;
    hsid_x_mon_code_e          fcode;

    logic unused_idle;
    assign unused_idle = ^idle;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        hsid_x_ctrl_mon_ch #(
            .RES_WIDTH (RES_WIDTH),
            .CNT_WIDTH (CNT_WIDTH),
            .TMO_WIDTH (TMO_WIDTH)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .mon_en    (mon_en),
            .mon_clear (mon_clear),
            .tmo_limit (tmo_limit),
            .start     (start[g]),
            .clear     (clear[g]),
            .done      (done[g]),
            .error     (error[g]),
            .cancelled (cancelled[g]),
            .res_src   (res_src[g*RES_WIDTH +: RES_WIDTH]),
            .res_reg   (res_reg[g*RES_WIDTH +: RES_WIDTH]),
            .viol      (viol[g]),
            .sticky    (viol_sticky[g*NV +: NV]),
            .cnt       (viol_cnt[g*CNT_WIDTH +: CNT_WIDTH])
        );
    end

    // Scan high to low so the lowest channel, then lowest code, is left standing.
    always_comb begin
        hit   = 1'b0;
        fch   = '0;
        fcode = MON_START_LONG;
        for (int c = NUM_CH-1; c >= 0; c--) begin
            for (int k = NV-1; k >= 0; k--) begin
                if (viol[c][k]) begin
                    hit   = 1'b1;
                    fch   = c[CH_W-1:0];
                    fcode = hsid_x_mon_code_e'(k[2:0]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_valid <= 1'b0;
            first_ch    <= '0;
            first_code  <= '0;
            irq         <= 1'b0;
        end else begin
            irq <= (irq & ~mon_clear) | hit;
            if (mon_clear) begin
                first_valid <= 1'b0;
                first_ch    <= '0;
                first_code  <= '0;
            end
            if ((mon_clear || !first_valid) && hit) begin
                first_valid <= 1'b1;
                first_ch    <= fch;
                first_code  <= fcode;
            end
        end
    end

endmodule

// File: tb/tb_hsid_x_ctrl_mon.sv
// Directed self-checking bench for hsid_x_ctrl_mon (default 4 channels, 8-bit counters).
module tb_hsid_x_ctrl_mon;

    localparam int NC = 4;
    localparam int RW = 80;
    localparam int CW = 8;
    localparam int TW = 16;
`ifdef HSID_X_MON_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              mon_en, mon_clear;
    logic [TW-1:0]     tmo_limit;
    logic [NC-1:0]     start, clear, idle, done, error, cancelled;
    logic [NC*RW-1:0]  res_src, res_reg;
    logic [NC*6-1:0]   viol_sticky;
    logic [NC*CW-1:0]  viol_cnt;
    logic              first_valid;
    logic [1:0]        first_ch;
    logic [2:0]        first_code;
    logic              irq;

    int n_cmp = 0;
    int n_bad = 0;

    hsid_x_ctrl_mon #(
        .NUM_CH(NC), .RES_WIDTH(RW), .CNT_WIDTH(CW), .TMO_WIDTH(TW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mon_en(mon_en), .mon_clear(mon_clear),
        .tmo_limit(tmo_limit), .start(start), .clear(clear), .idle(idle),
        .done(done), .error(error), .cancelled(cancelled),
        .res_src(res_src), .res_reg(res_reg), .viol_sticky(viol_sticky),
        .viol_cnt(viol_cnt), .first_valid(first_valid), .first_ch(first_ch),
        .first_code(first_code), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CW-1:0] cnt_of(input int ch);
        return viol_cnt[ch*CW +: CW];
    endfunction

    task automatic clr_mon();
        mon_clear = 1'b1;
        tick();
        mon_clear = 1'b0;
    endtask

    initial begin
        mon_en = 1'b1; mon_clear = 1'b0; tmo_limit = '0;
        start = '0; clear = '0; idle = '1; done = '0; error = '0; cancelled = '0;
        res_src = '0; res_reg = '0;
        #12 rst_n = 1'b1;
        tick();
        chk("rst_sticky", viol_sticky, 0);
        chk("rst_cnt",    viol_cnt,    0);
        chk("rst_fvalid", first_valid, 0);
        chk("rst_irq",    irq,         0);

        // ch0 clean episode
        start[0] = 1'b1; tick(); start[0] = 1'b0;
        repeat (4) tick();
        res_src[0 +: RW] = 80'hABCD; res_reg[0 +: RW] = 80'hABCD;
        done[0] = 1'b1; tick(); done[0] = 1'b0;
        tick(); tick();
        chk("clean_sticky", viol_sticky, 0);
        chk("clean_irq",    irq,         0);

        // ch1 start held two cycles
        start[1] = 1'b1; tick();
        chk("sl_irq_early", irq, 0);
        tick(); start[1] = 1'b0;
        chk("sl_flag",  viol_sticky[1*6+0], 1);
        chk("sl_cnt",   cnt_of(1),          1);
        chk("sl_fvld",  first_valid,        1);
        chk("sl_fch",   first_ch,           1);
        chk("sl_fcode", first_code,         0);
        chk("sl_irq",   irq,                1);
        clear[1] = 1'b1; tick(); clear[1] = 1'b0;
        clr_mon();
        chk("clr_sticky", viol_sticky, 0);
        chk("clr_cnt",    viol_cnt,    0);
        chk("clr_fvld",   first_valid, 0);
        chk("clr_irq",    irq,         0);

        // ch2 multi interruption then result mismatch
        start[2] = 1'b1; tick(); start[2] = 1'b0; tick();
        done[2] = 1'b1; error[2] = 1'b1; tick();
        done[2] = 1'b0; error[2] = 1'b0;
        chk("mi_flag",     viol_sticky[2*6+3], 1);
        chk("mi_res_early", viol_sticky[2*6+4], 0);
        chk("mi_cnt",      cnt_of(2),          1);
        res_reg[2*RW +: RW] = 80'h1234;
        tick();
        res_reg[2*RW +: RW] = '0;
        chk("rm_flag",  viol_sticky[2*6+4], 1);
        chk("rm_cnt",   cnt_of(2),          2);
        chk("rm_fch",   first_ch,           2);
        chk("rm_fcode", first_code,         3);
        tick();
        clr_mon();

        // ch0 START_BUSY and ch3 START_LONG in the same cycle
        start[0] = 1'b1; tick(); start[0] = 1'b0;
        start[3] = 1'b1; tick();
        start[0] = 1'b1; tick(); start[0] = 1'b0;
        chk("pri_fch",   first_ch,           0);
        chk("pri_fcode", first_code,         2);
        chk("pri_ch0",   viol_sticky[0*6+2], 1);
        chk("pri_ch3",   viol_sticky[3*6+0], 1);
        mon_clear = 1'b1; tick(); mon_clear = 1'b0;
        chk("cv_sticky", viol_sticky, 64'h1 << 18);
        chk("cv_cnt3",   cnt_of(3),   1);
        chk("cv_cnt0",   cnt_of(0),   0);
        chk("cv_fch",    first_ch,    3);
        chk("cv_fcode",  first_code,  0);
        chk("cv_irq",    irq,         1);
        start[3] = 1'b0; clear = 4'b1001; tick(); clear = '0;
        clr_mon();

        // watchdog: 12 RUN cycles with limit 10
        tmo_limit = 16'd10;
        start[0] = 1'b1; tick(); start[0] = 1'b0;
        repeat (11) tick();
        clear[0] = 1'b1; tick(); clear[0] = 1'b0;
        chk("wd_sticky", viol_sticky, WD ? 64'h20 : 64'h0);
        chk("wd_cnt",    cnt_of(0),   WD ? 1 : 0);
        chk("wd_irq",    irq,         WD);
        tmo_limit = '0;
        clr_mon();

        // counter saturation
        start[1] = 1'b1;
        repeat (300) tick();
        chk("sat_cnt",  cnt_of(1),          255);
        chk("sat_flag", viol_sticky[1*6+0], 1);
        start[1] = 1'b0;
        clr_mon();
        chk("sat_clr", cnt_of(1), 0);

        // masked detection
        mon_en = 1'b0; start[1] = 1'b1;
        repeat (3) tick();
        chk("mask_sticky", viol_sticky, 0);
        start[1] = 1'b0; mon_en = 1'b1; tick();
        chk("reen_sticky", viol_sticky, 0);

        // asynchronous reset with ch1 still in RUN
        done[3] = 1'b1; error[3] = 1'b1; tick();
        done[3] = 1'b0; error[3] = 1'b0;
        chk("prerst_irq", irq, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sticky", viol_sticky, 0);
        chk("arst_cnt",    viol_cnt,    0);
        chk("arst_fvld",   first_valid, 0);
        chk("arst_fcode",  first_code,  0);
        chk("arst_irq",    irq,         0);
        #3 rst_n = 1'b1;
        tick();
        start[1] = 1'b1; tick(); start[1] = 1'b0; tick();
        chk("post_rst_idle", viol_sticky, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hsid_x_ctrl_mon.md
# hsid_x_ctrl_mon

Synthesizable, multi-channel runtime protocol monitor for HSpecID-X accelerator control handshakes. It sits beside the register block of up to NUM_CH accelerator instances and checks, in silicon, the rules the simulation checker only asserts. Checked rules: single-cycle start/clear, result-register update after an interruption, start-while-busy, one-hot interruption and an optional busy watchdog. Violations are reported through sticky flags, saturating counters, first-error capture and a level interrupt.

## Interface
- NUM_CH, 4, number of monitored accelerator channels (1..16)
- RES_WIDTH, 2*HSID_WORD_WIDTH+2*HSID_HSP_LIBRARY_WIDTH, width of one channel's packed result (min/max ref and value)
- CNT_WIDTH, 8, per-channel violation counter width
- TMO_WIDTH, 16, watchdog counter width
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mon_en  in  1  checking enable; when low no violation is recorded, FSMs still track
- mon_clear  in  1  clears sticky flags, counters, first-capture and irq
- tmo_limit  in  TMO_WIDTH  busy-cycle limit; 0 disables watchdog
- start, clear, idle, done, error, cancelled  in  NUM_CH each  per-channel handshake bits
- res_src  in  NUM_CH*RES_WIDTH  accelerator result outputs
- res_reg  in  NUM_CH*RES_WIDTH  hw2reg result fields
- viol_sticky  out  NUM_CH*6  sticky flag per channel per code
- viol_cnt  out  NUM_CH*CNT_WIDTH  violating-cycle count per channel
- first_valid  out  1  first violation captured
- first_ch  out  $clog2(NUM_CH)  channel of first violation (width 1 when NUM_CH=1)
- first_code  out  3  code of first violation
- irq  out  1  OR of all sticky flags

## Operation
- Codes: 0 START_LONG, 1 CLEAR_LONG, 2 START_BUSY, 3 MULTI_INT, 4 RES_MISMATCH, 5 TIMEOUT.
- Per-channel FSM: IDLE, RUN, RES_CHK.
  - IDLE: start → RUN.
  - RUN: any of done/error/cancelled → RES_CHK; clear → IDLE; interruption has priority over clear.
  - RES_CHK: one cycle. Goes to RUN if start, else IDLE.
- START_LONG: start high this cycle and the previous cycle.
- CLEAR_LONG: clear high this cycle and the previous cycle.
- START_BUSY: start rises (previous cycle low) while FSM is in RUN.
- MULTI_INT: more than one of done/error/cancelled high in the same cycle.
- RES_MISMATCH: in RES_CHK, res_reg slice ≠ res_src slice.
- TIMEOUT: busy counter reaches tmo_limit while in RUN. Flagged once per RUN episode.
- Busy counter behaviour:
  - Resets on entry to RUN and increments each RUN cycle.
  - Saturates at its maximum value.
- viol_cnt increments by 1 per cycle in which that channel has ≥1 new violation, and saturates at all-ones.
- First capture:
  - Latched only when first_valid is 0.
  - On simultaneous violations, the lowest channel wins, then the lowest code.
- mon_clear with a same-cycle violation: the clear applies, then the new violation is recorded (violation wins).

## Timing
- All outputs are registered. A violation detected in cycle N appears on viol_sticky, viol_cnt, first_* and irq at cycle N+1.
- RES_MISMATCH compares in the cycle after the interruption and is reported one cycle after that, i.e. interruption + 2.
- Reset values:
  - FSMs: IDLE.
  - Counters, flags, first_valid, first_ch, first_code, irq: 0.
  - Previous-cycle start/clear history: 0.
- Reset mid-RUN discards all state. No violation is generated for the aborted episode.
- mon_en low: detection is masked, but FSMs and history registers still update. Re-enabling therefore causes no spurious START_LONG.

## Configuration
- HSID_X_MON_WATCHDOG_EN defined: busy counters, tmo_limit compare and code 5 are present.
- HSID_X_MON_WATCHDOG_EN undefined:
  - tmo_limit is ignored.
  - Code-5 sticky bits are tied to 0.
  - Busy counters are removed.

## Structure
- hsid_pkg holds:
  - hsid_x_mon_code_e enum (3-bit).
  - HSID_X_MON_NUM_VIOL = 6.
  - hsid_x_mon_state_e (IDLE/RUN/RES_CHK).
- Sub-module hsid_x_ctrl_mon_ch: one channel's FSM, history, detectors, busy counter, sticky bits and counter. It is instantiated NUM_CH times via generate.
- Top level: first-violation priority encoder and irq OR.

## Test plan
- Ch0: start 1 cycle, done 5 cycles later, res_reg = res_src at N+1 → no flags, irq stays 0.
- Ch1: start held 2 cycles → viol_sticky[1*6+0]=1, viol_cnt[1]=1, first_ch=1, first_code=0, irq=1 on the cycle after the second high cycle.
- Ch2: done and error together → code 3 set; additionally res_reg ≠ res_src at interruption+1 → code 4 set at interruption+2, viol_cnt[2]=2.
- Ch0 and ch3 violate in the same cycle (codes 2 and 0) → first_ch=0, first_code=2; mon_clear plus a new ch3 violation in the same cycle → only the ch3 flag remains set.
- tmo_limit=10, ch0 in RUN for 12 cycles (watchdog build) → code 5 set once; same stimulus in a no-watchdog build → no flags.
- 300 consecutive START_LONG cycles with CNT_WIDTH=8 → viol_cnt saturates at 255. Reset asserted mid-RUN → all outputs 0 immediately.
